gesture_match_ctrl: RTL and testbench
=====================================

Name: gesture_match_ctrl

Overview:
- Sequencer in front of the gesture dot-product engine.
- Captures the real-time motion-vector stream (one 16-vector frame per video frame) into a ping-pong buffer.
- For each captured frame, walks the template library ROM, streams aligned vector/template pairs to the external MAC, and collects one dot product per template.
- Reports the best-matching template index and its score.

Parameters:
- NUM_TMPL, 26, number of library templates.
- VEC_N, 16, vectors per frame (power of two).
- VW, 6, signed vector component width.
- SW, 16, signed dot-product / score width.
- THRESH, 0, minimum winning score; a best score below this reports NO_MATCH.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  stream vector valid.
- i_index  in  4  element index within frame (0..VEC_N-1).
- i_vec_x  in  VW  signed x component.
- i_vec_y  in  VW  signed y component.
- i_frame_end  in  1  qualified by i_valid; marks the last vector of the frame.
- o_lib_addr  out  9  library ROM address, equal to template*VEC_N + element.
- o_lib_rd  out  1  ROM read strobe; data returns exactly 1 cycle later.
- i_lib_x  in  VW  ROM x data.
- i_lib_y  in  VW  ROM y data.
- o_mac_valid  out  1  pair valid to MAC.
- o_mac_first  out  1  first element of a template; MAC clears its accumulator.
- o_mac_last  out  1  last element of a template.
- o_vec_x  out  VW  buffered vector x.
- o_vec_y  out  VW  buffered vector y.
- o_lib_x  out  VW  registered ROM x.
- o_lib_y  out  VW  registered ROM y.
- i_dot_valid  in  1  MAC result valid (any latency ≥1).
- i_dot  in  SW  signed dot product.
- o_valid  out  1  one-cycle result pulse.
- o_index  out  5  winning template, or NO_MATCH = 5'd31.
- o_score  out  SW  winning score.
- o_busy  out  1  match pass in progress.
- o_drop  out  1  one-cycle pulse: a frame was discarded.

Behaviour:
- Reset: all outputs 0; both banks empty; write bank = 0; FSM in IDLE.
- Capture:
  - i_valid writes bank wr_bank[i_index].
  - i_valid & i_frame_end marks wr_bank full and toggles wr_bank.
  - If the target bank is full (one bank matching, the other pending), writes are ignored. On that frame's i_frame_end, o_drop pulses in the next cycle.
  - A partial frame (no frame_end) is overwritten by the next frame.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On any full bank, latch rd_bank = oldest full bank, clear cnt and res_cnt, go ISSUE.
  - If both banks are full, the bank filled first is processed first.
- ISSUE:
  - Each cycle: o_lib_rd = 1, o_lib_addr = cnt, buffer element cnt[3:0] read; cnt increments.
  - One cycle later: o_mac_valid = 1 with the buffered vector (delayed 1 cycle) aligned to i_lib_x/y.
  - o_mac_first = (element == 0); o_mac_last = (element == VEC_N-1).
  - After cnt = NUM_TMPL*VEC_N-1 (415), go DRAIN.
  - Total pairs issued = 416, with no gaps.
- Result collection (ISSUE or DRAIN):
  - Each i_dot_valid increments res_cnt.
  - Argmax: the first result initialises best; later results replace it only if strictly greater (ties keep the lower index).
  - i_dot_valid in IDLE/DONE is ignored.
- DRAIN: when res_cnt == NUM_TMPL, go DONE.
- DONE:
  - o_valid = 1 for one cycle.
  - o_index = best index, or 31 if best < THRESH.
  - o_score = best score.
  - rd_bank is marked empty; return to IDLE.
  - o_index and o_score hold until the next DONE.
- o_busy = 1 in ISSUE, DRAIN and DONE.
- Simultaneous events:
  - A frame_end for bank B in the same cycle as DONE releasing bank A is accepted, not dropped.
  - Capture into the free bank proceeds during a pass.
- Reset mid-pass aborts the pass immediately; both banks are cleared; no o_valid is issued.

Decomposition:
- Package gesture_pkg: VW, SW, VEC_N, NUM_TMPL, NO_MATCH = 5'd31, the FSM state enum, and typedef vec_t (signed [VW-1:0] x, y).
- Sub-module vec_pingpong_buf:
  - Two banks of VEC_N vec_t, with full flags and write-bank toggling.
  - 1-cycle registered read port.
  - Drop detection.
- Controller FSM, address counter and argmax stay in gesture_match_ctrl.

Test Plan:
- Single frame, all vectors (1,0), library template 7 all (5,0) and others 0, ideal MAC with 2-cycle latency:
  - Exactly 416 consecutive o_mac_valid beats.
  - o_valid 1 cycle after the 26th result.
  - o_index = 7, o_score = 80.
- Tie: templates 3 and 12 both score 40 → o_index = 3.
- All templates negative (best −16) with THRESH = 0 → o_index = 31, o_score = −16.
- Three back-to-back frames while the first pass is busy:
  - Frame 2 becomes pending; frame 3 is dropped with one o_drop pulse.
  - Two o_valid pulses, in frame order.
- Alignment check: at beat k of ISSUE, o_lib_addr = k, and the next-cycle o_vec_* equals buffer[k mod 16].
  - first/last are asserted at elements 0/15 of every template.
- Assert i_rst_n low at cycle 200 of ISSUE:
  - All outputs 0, no o_valid.
  - A fresh frame afterwards matches normally.

Source files
------------

// File: rtl/gesture_pkg.sv
// Shared types and sizing for the gesture match sequencer.
// Vector/score widths, library geometry, the controller state enum and the stream vector type.
package gesture_pkg;

    localparam int VW       = 6;
    localparam int SW       = 16;
    localparam int VEC_N    = 16;
    localparam int NUM_TMPL = 26;

    localparam int IDX_W  = $clog2(VEC_N);
    localparam int ADDR_W = $clog2(NUM_TMPL * VEC_N);
    localparam int TMPL_W = 5;

    localparam logic [TMPL_W-1:0] NO_MATCH = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic signed [VW-1:0] x;
        logic signed [VW-1:0] y;
    } vec_t;

endpackage

// File: rtl/vec_pingpong_buf.sv
// Two-bank capture buffer for the motion-vector stream: fills one bank while the other is matched,
// tracks which full bank is oldest, and flags frames that arrive when the target bank is still busy.
module vec_pingpong_buf
    import gesture_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_valid,
    input  logic [IDX_W-1:0] i_wr_index,
    input  vec_t             i_wr_vec,
    input  logic             i_wr_frame_end,
    input  logic             i_release,
    input  logic             i_rel_bank,
    input  logic             i_rd_en,
    input  logic             i_rd_bank,
    input  logic [IDX_W-1:0] i_rd_index,
    output vec_t             o_rd_vec,
    output logic             o_any_full,
    output logic             o_oldest_bank,
    output logic             o_drop
);

    vec_t       mem [2][VEC_N];
    vec_t       rd_vec_q;
    logic [1:0] full_q;
    logic [1:0] full_cleared;
    logic [1:0] full_d;
    logic       wr_bank_q;
    logic       oldest_q;
    logic       drop_q;
    logic       bank_free;
    logic       frame_end;
    logic       accept_end;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        full_cleared = full_q;
        if (i_release) begin
            full_cleared[i_rel_bank] = 1'b0;
        end
        // A bank being released this cycle is already free for the incoming frame.
        bank_free  = !full_cleared[wr_bank_q];
        frame_end  = i_wr_valid && i_wr_frame_end;
        accept_end = frame_end && bank_free;
        full_d     = full_cleared;
        if (accept_end) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // NOTE: the vector storage has no reset; the full flags alone decide whether a bank holds a frame.
    always_ff @(posedge i_clk) begin
        if (i_wr_valid && bank_free) begin
            mem[wr_bank_q][i_wr_index] <= i_wr_vec;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            oldest_q  <= 1'b0;
            drop_q    <= 1'b0;
            rd_vec_q  <= '0;
        end else begin
            full_q <= full_d;
            drop_q <= frame_end && !bank_free;
            if (accept_end) begin
                wr_bank_q <= ~wr_bank_q;
                oldest_q  <= full_cleared[~wr_bank_q] ? ~wr_bank_q : wr_bank_q;
            end
            if (i_rd_en) begin
                rd_vec_q <= mem[i_rd_bank][i_rd_index];
            end
        end
    end

    // With both banks full the older one wins; otherwise whichever single bank is full.
    assign o_oldest_bank = (&full_q) ? oldest_q : full_q[1];
    assign o_any_full    = |full_q;
    assign o_drop        = drop_q;
    assign o_rd_vec      = rd_vec_q;

endmodule

// File: rtl/gesture_match_ctrl.sv
// Sequencer for the gesture dot-product engine: captures frames, streams vector/template pairs
// to the external MAC, and reports the best-scoring library template.
module gesture_match_ctrl
    import gesture_pkg::*;
#(
    parameter int THRESH = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [IDX_W-1:0]     i_index,
    input  logic signed [VW-1:0] i_vec_x,
    input  logic signed [VW-1:0] i_vec_y,
    input  logic                 i_frame_end,
    output logic [ADDR_W-1:0]    o_lib_addr,
    output logic                 o_lib_rd,
    input  logic signed [VW-1:0] i_lib_x,
    input  logic signed [VW-1:0] i_lib_y,
    output logic                 o_mac_valid,
    output logic                 o_mac_first,
    output logic                 o_mac_last,
    output logic signed [VW-1:0] o_vec_x,
    output logic signed [VW-1:0] o_vec_y,
    output logic signed [VW-1:0] o_lib_x,
    output logic signed [VW-1:0] o_lib_y,
    input  logic                 i_dot_valid,
    input  logic signed [SW-1:0] i_dot,
    output logic                 o_valid,
    output logic [TMPL_W-1:0]    o_index,
    output logic signed [SW-1:0] o_score,
    output logic                 o_busy,
    output logic                 o_drop
);

    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NUM_TMPL * VEC_N - 1);
    localparam logic [TMPL_W-1:0]    RES_ALL   = TMPL_W'(NUM_TMPL);
    localparam logic [TMPL_W-1:0]    RES_PREV  = TMPL_W'(NUM_TMPL - 1);
    localparam logic [IDX_W-1:0]     LAST_ELEM = IDX_W'(VEC_N - 1);
    localparam logic signed [SW-1:0] THRESH_S  = SW'(THRESH);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_W-1:0]     cnt_q;
    logic [TMPL_W-1:0]     res_cnt_q;
    logic                  rd_bank_q;
    logic signed [SW-1:0]  best_score_q;
    logic [TMPL_W-1:0]     best_idx_q;
    logic                  best_vld_q;
    logic                  mac_valid_q;
    logic                  mac_first_q;
    logic                  mac_last_q;
    logic [TMPL_W-1:0]     out_index_q;
    logic signed [SW-1:0]  out_score_q;
    logic                  lib_rd;
    logic                  release_bank;
    logic                  dot_take;
    logic [TMPL_W-1:0]     final_index;
    logic                  any_full;
    logic                  oldest_bank;
    vec_t                  buf_vec;
    vec_t                  wr_vec;

    assign wr_vec = '{x: i_vec_x, y: i_vec_y};

    vec_pingpong_buf u_buf (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_wr_valid     (i_valid),
        .i_wr_index     (i_index),
        .i_wr_vec       (wr_vec),
        .i_wr_frame_end (i_frame_end),
        .i_release      (release_bank),
        .i_rel_bank     (rd_bank_q),
        .i_rd_en        (lib_rd),
        .i_rd_bank      (rd_bank_q),
        .i_rd_index     (cnt_q[IDX_W-1:0]),
        .o_rd_vec       (buf_vec),
        .o_any_full     (any_full),
        .o_oldest_bank  (oldest_bank),
        .o_drop         (o_drop)
    );

    assign dot_take    = i_dot_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN)
                         && (res_cnt_q < RES_ALL);
    assign final_index = (best_score_q < THRESH_S) ? NO_MATCH : best_idx_q;

    always_comb begin
        state_d      = state_q;
        lib_rd       = 1'b0;
        release_bank = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_full) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                lib_rd = 1'b1;
                if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as the last result lands so o_valid follows it by one cycle.
                if (res_cnt_q == RES_ALL || (dot_take && res_cnt_q == RES_PREV)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                release_bank = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            res_cnt_q    <= '0;
            rd_bank_q    <= 1'b0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            best_vld_q   <= 1'b0;
            out_index_q  <= '0;
            out_score_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && any_full) begin
                rd_bank_q  <= oldest_bank;
                cnt_q      <= '0;
                res_cnt_q  <= '0;
                best_vld_q <= 1'b0;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Results arrive in template order, so res_cnt is the template index; ties keep the lower one.
            if (dot_take) begin
                res_cnt_q <= res_cnt_q + 1'b1;
                if (!best_vld_q || i_dot > best_score_q) begin
                    best_score_q <= i_dot;
                    best_idx_q   <= res_cnt_q;
                    best_vld_q   <= 1'b1;
                end
            end
            if (state_q == ST_DONE) begin
                out_index_q <= final_index;
                out_score_q <= best_score_q;
            end
        end
    end

    // Pair qualifiers line up with the ROM data and buffer read that return one cycle after the read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            mac_valid_q <= lib_rd;
            mac_first_q <= lib_rd && (cnt_q[IDX_W-1:0] == '0);
            mac_last_q  <= lib_rd && (cnt_q[IDX_W-1:0] == LAST_ELEM);
        end
    end

    assign o_lib_rd    = lib_rd;
    assign o_lib_addr  = lib_rd ? cnt_q : '0;
    assign o_mac_valid = mac_valid_q;
    assign o_mac_first = mac_first_q;
    assign o_mac_last  = mac_last_q;
    assign o_vec_x     = mac_valid_q ? buf_vec.x : '0;
    assign o_vec_y     = mac_valid_q ? buf_vec.y : '0;
    assign o_lib_x     = mac_valid_q ? i_lib_x : '0;
    assign o_lib_y     = mac_valid_q ? i_lib_y : '0;
    assign o_valid     = (state_q == ST_DONE);
    assign o_index     = (state_q == ST_DONE) ? final_index : out_index_q;
    assign o_score     = (state_q == ST_DONE) ? best_score_q : out_score_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gesture_match_ctrl.sv
// Scoreboard bench for gesture_match_ctrl with a registered library ROM model and a 2-cycle ideal MAC.
module tb_gesture_match_ctrl;
    import gesture_pkg::*;

    localparam int NADDR = NUM_TMPL * VEC_N;
    localparam int THRESH_TB = 0;

    typedef logic [VEC_N-1:0][2*VW-1:0] frame_t;
    typedef struct { int idx; int score; } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 valid;
    logic [IDX_W-1:0]     index;
    logic signed [VW-1:0] vec_x, vec_y;
    logic                 frame_end;
    logic [ADDR_W-1:0]    o_lib_addr;
    logic                 o_lib_rd;
    logic signed [VW-1:0] lib_x, lib_y;
    logic                 o_mac_valid, o_mac_first, o_mac_last;
    logic signed [VW-1:0] o_vec_x, o_vec_y, o_lib_x, o_lib_y;
    logic                 dot_valid;
    logic signed [SW-1:0] dot;
    logic                 o_valid;
    logic [TMPL_W-1:0]    o_index;
    logic signed [SW-1:0] o_score;
    logic                 o_busy, o_drop;

    gesture_match_ctrl #(.THRESH(THRESH_TB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_index(index),
        .i_vec_x(vec_x), .i_vec_y(vec_y), .i_frame_end(frame_end),
        .o_lib_addr(o_lib_addr), .o_lib_rd(o_lib_rd), .i_lib_x(lib_x), .i_lib_y(lib_y),
        .o_mac_valid(o_mac_valid), .o_mac_first(o_mac_first), .o_mac_last(o_mac_last),
        .o_vec_x(o_vec_x), .o_vec_y(o_vec_y), .o_lib_x(o_lib_x), .o_lib_y(o_lib_y),
        .i_dot_valid(dot_valid), .i_dot(dot), .o_valid(o_valid), .o_index(o_index),
        .o_score(o_score), .o_busy(o_busy), .o_drop(o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Library ROM model: one-cycle registered read.
    int rom_x [NADDR];
    int rom_y [NADDR];
    always @(posedge clk) begin
        if (o_lib_rd) begin
            lib_x <= VW'(rom_x[o_lib_addr]);
            lib_y <= VW'(rom_y[o_lib_addr]);
        end
    end

    // Ideal MAC: result appears two cycles after the last pair of a template.
    int mac_acc, mac_p, mac_a, mac_d1;
    logic mac_dv1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_acc <= 0; mac_dv1 <= 1'b0; mac_d1 <= 0;
            dot_valid <= 1'b0; dot <= '0;
        end else begin
            mac_p = int'(o_vec_x) * int'(o_lib_x) + int'(o_vec_y) * int'(o_lib_y);
            mac_a = o_mac_first ? mac_p : mac_acc + mac_p;
            if (o_mac_valid) mac_acc <= mac_a;
            mac_dv1   <= o_mac_valid && o_mac_last;
            mac_d1    <= mac_a;
            dot_valid <= mac_dv1;
            dot       <= SW'(mac_d1);
        end
    end

    function automatic int fx(input frame_t f, input int e);
        logic signed [VW-1:0] v;
        v = f[e][2*VW-1:VW];
        return int'(v);
    endfunction

    function automatic int fy(input frame_t f, input int e);
        logic signed [VW-1:0] v;
        v = f[e][VW-1:0];
        return int'(v);
    endfunction

    function automatic frame_t mk_frame(input int x, input int y);
        frame_t f;
        for (int e = 0; e < VEC_N; e++) f[e] = {VW'(x), VW'(y)};
        return f;
    endfunction

    function automatic exp_t model(input frame_t f);
        exp_t r;
        int s;
        r.idx = 0; r.score = 0;
        for (int t = 0; t < NUM_TMPL; t++) begin
            s = 0;
            for (int e = 0; e < VEC_N; e++)
                s += fx(f, e) * rom_x[t*VEC_N+e] + fy(f, e) * rom_y[t*VEC_N+e];
            if (t == 0 || s > r.score) begin r.score = s; r.idx = t; end
        end
        if (r.score < THRESH_TB) r.idx = 31;
        return r;
    endfunction

    exp_t   exp_q[$];
    frame_t pass_frames[$];

    // Output monitor, sampled on the falling edge.
    int   cyc = 0;
    int   run = 0, issue_k = 0, align_err = 0, drop_cnt = 0, valid_cnt = 0;
    int   res_seen = 0, last_res_cyc = 0, prev_addr = 0, mon_e;
    logic prev_rd = 1'b0;
    exp_t mon_exp;
    frame_t mon_fr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0; issue_k = 0; prev_rd = 1'b0; res_seen = 0; align_err = 0;
        end else begin
            if (o_mac_valid) begin
                mon_e = prev_addr % VEC_N;
                if (!prev_rd || pass_frames.size() == 0) begin
                    align_err++;
                end else begin
                    mon_fr = pass_frames[0];
                    if (int'(o_vec_x) != fx(mon_fr, mon_e) || int'(o_vec_y) != fy(mon_fr, mon_e) ||
                        int'(o_lib_x) != rom_x[prev_addr] || int'(o_lib_y) != rom_y[prev_addr] ||
                        o_mac_first != (mon_e == 0) || o_mac_last != (mon_e == VEC_N-1))
                        align_err++;
                end
                run++;
            end else if (run != 0) begin
                check("beat_run", run, NADDR);
                run = 0;
            end
            if (o_lib_rd) begin
                if (int'(o_lib_addr) != issue_k) align_err++;
                issue_k++;
            end else begin
                issue_k = 0;
            end
            prev_rd   = o_lib_rd;
            prev_addr = int'(o_lib_addr);
            if (o_drop) drop_cnt++;
            if (dot_valid) begin
                res_seen++;
                if (res_seen == NUM_TMPL) last_res_cyc = cyc;
            end
            if (o_valid) begin
                valid_cnt++;
                check("valid_lat", cyc - last_res_cyc, 1);
                check("busy_done", int'(o_busy), 1);
                check("align_err", align_err, 0);
                align_err = 0;
                res_seen  = 0;
                if (exp_q.size() == 0) begin
                    check("sb_pending", exp_q.size(), 1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("index", int'(o_index), mon_exp.idx);
                    check("score", int'(o_score), mon_exp.score);
                end
                if (pass_frames.size() != 0) void'(pass_frames.pop_front());
            end
        end
    end

    task automatic send_frame(input frame_t f, input bit keep);
        if (keep) begin
            exp_q.push_back(model(f));
            pass_frames.push_back(f);
        end
        for (int i = 0; i < VEC_N; i++) begin
            @(posedge clk); #1;
            valid     = 1'b1;
            index     = IDX_W'(i);
            vec_x     = f[i][2*VW-1:VW];
            vec_y     = f[i][VW-1:0];
            frame_end = (i == VEC_N-1);
        end
        @(posedge clk); #1;
        valid = 1'b0; frame_end = 1'b0;
    endtask

    task automatic wait_valids(input int target, input int budget);
        int n = 0;
        while (valid_cnt < target && n < budget) begin
            @(posedge clk); n++;
        end
        check("wait_valid", valid_cnt, target);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < NADDR; a++) begin rom_x[a] = 0; rom_y[a] = 0; end
    endtask

    task automatic rom_fill(input int t, input int x, input int y);
        for (int e = 0; e < VEC_N; e++) begin rom_x[t*VEC_N+e] = x; rom_y[t*VEC_N+e] = y; end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, int'(o_valid), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_lib_rd"}, int'(o_lib_rd), 0);
        check({tag, "_mac_valid"}, int'(o_mac_valid), 0);
        check({tag, "_index"}, int'(o_index), 0);
        check({tag, "_score"}, int'(o_score), 0);
        check({tag, "_drop"}, int'(o_drop), 0);
        check({tag, "_addr"}, int'(o_lib_addr), 0);
        check({tag, "_vec_x"}, int'(o_vec_x), 0);
        check({tag, "_lib_x"}, int'(o_lib_x), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int v0, d0, n;

    initial begin
        rst_n = 1'b0; valid = 1'b0; index = '0; vec_x = '0; vec_y = '0; frame_end = 1'b0;
        lib_x = '0; lib_y = '0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single frame, template 7 is the only non-zero entry.
        clear_rom();
        rom_fill(7, 5, 0);
        send_frame(mk_frame(1, 0), 1'b1);
        wait_valids(1, 2000);
        repeat (20) @(posedge clk);
        #1;
        check("hold_index", int'(o_index), 7);
        check("hold_score", int'(o_score), 80);
        check("idle_busy", int'(o_busy), 0);

        // Tie between templates 3 and 12: the lower index wins.
        clear_rom();
        for (int e = 0; e < VEC_N; e++) begin
            rom_x[3*VEC_N+e]  = (e < 8) ? 3 : 2;
            rom_x[12*VEC_N+e] = (e < 8) ? 3 : 2;
        end
        send_frame(mk_frame(1, 0), 1'b1);
        wait_valids(2, 2000);

        // Every template negative: best is -16, below threshold.
        clear_rom();
        for (int t = 0; t < NUM_TMPL; t++) rom_fill(t, (t % 2 == 0) ? -1 : -2, 0);
        send_frame(mk_frame(1, 0), 1'b1);
        wait_valids(3, 2000);

        // Three back-to-back frames: second pends, third is dropped.
        clear_rom();
        rom_fill(5, 2, 0);
        rom_fill(9, 0, 3);
        d0 = drop_cnt;
        send_frame(mk_frame(1, 0), 1'b1);
        send_frame(mk_frame(0, 1), 1'b1);
        send_frame(mk_frame(-1, -1), 1'b0);
        wait_valids(5, 3000);
        check("drop_count", drop_cnt - d0, 1);

        // Reset in the middle of the address walk.
        clear_rom();
        rom_fill(7, 5, 0);
        send_frame(mk_frame(1, 0), 1'b1);
        n = 0;
        while (issue_k < 200 && n < 1000) begin
            @(posedge clk); n++;
        end
        check("reach_issue_200", issue_k, 200);
        #1 rst_n = 1'b0;
        #1 check_quiet("midreset");
        v0 = valid_cnt;
        repeat (2) @(posedge clk);
        exp_q.delete();
        pass_frames.delete();
        #1 rst_n = 1'b1;
        repeat (500) @(posedge clk);
        check("no_valid_after_rst", valid_cnt, v0);
        check("banks_cleared", int'(o_busy), 0);
        send_frame(mk_frame(1, 0), 1'b1);
        wait_valids(v0 + 1, 2000);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
